icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch queue (IF).
- Accepts one PC lookup at a time from IF and returns the 32-bit instruction word.
- On a miss, refills a whole line word-by-word from the memory controller.
- Hits return in 1 cycle; misses stall the requester until the line fill completes.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines).
- WORD_OFF_BITS, 2, log2 of words per line (4 words = 16 bytes).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; when 0 all state holds.
- if_req_valid  in  1  IF presents a PC.
- if_pc  in  32  fetch byte address; bits [1:0] ignored.
- if_req_ready  out  1  cache can accept a lookup.
- flush_in  in  1  pipeline redirect; cancels the pending fetch.
- instr_valid  out  1  one-cycle pulse: instr_out is valid.
- instr_out  out  32  fetched instruction.
- mem_req_valid  out  1  word read request to memory controller.
- mem_req_addr  out  32  word-aligned request address.
- mem_resp_valid  in  1  memory returns the requested word (one-cycle pulse).
- mem_resp_data  in  32  returned word.

Behaviour:
- Address split: tag = [31:2+WORD_OFF_BITS+INDEX_BITS]; index = next INDEX_BITS; word = [2+WORD_OFF_BITS-1:2].
- Storage: per-line valid bit, tag, and 2^WORD_OFF_BITS data words.
- Reset (rst_in=0, async):
  - all valid bits cleared; state=IDLE.
  - instr_valid=0, instr_out=0, mem_req_valid=0, mem_req_addr=0.
  - Any fill in progress is abandoned; the line is not validated.
- rdy_in=0: no register changes; outputs hold their values.
- States:
  - IDLE: if_req_ready=1. Accept when if_req_valid && !flush_in, and latch the PC.
    - Hit (valid && tag match): next cycle instr_valid=1 with the word; stay IDLE.
    - Miss: go to FILL with fill counter=0.
  - FILL: if_req_ready=0.
    - mem_req_valid=1, mem_req_addr = {tag, index, counter, 2'b00}.
    - Each mem_resp_valid writes data[index][counter] and increments the counter.
    - Last word: write tag and set valid in the same edge; go to RESP.
    - mem_req_valid deasserts in the cycle after the last response.
  - RESP: instr_valid=1 with the requested word from the just-filled line, unless cancelled; go to IDLE.
- Latency:
  - Hit: 1 cycle (accepted at edge N, instr_valid high during cycle N+1).
  - Miss: 1 + sum of 4 memory round trips + 1.
- Throughput: back-to-back hits allowed, one per cycle.
- flush_in:
  - IDLE: no request accepted that cycle; a hit response not yet emitted is suppressed.
  - FILL: the fill runs to completion (memory protocol never aborted) and the line is validated; a cancel flag suppresses the RESP pulse.
  - The cancel flag clears on return to IDLE.
- Conflict: a miss to a valid line with a different tag overwrites it. There is no write path and no coherence.
- Memory responses arriving in IDLE or RESP are ignored.
- if_pc is sampled only on accept; later changes do not affect an in-flight fill.

Test Plan:
- Cold miss: reset, request pc=0x0000_1004, memory returns 0xA0,0xA1,0xA2,0xA3 at 2-cycle latency -> mem_req_addr 0x1000,0x1004,0x1008,0x100C in order; instr_valid once with instr_out=0xA1.
- Hit after fill: request pc=0x100C right after the above -> instr_valid next cycle, instr_out=0xA3, mem_req_valid stays 0.
- Conflict eviction: fill 0x1000, then request 0x1400 (same index, different tag) -> refill from 0x1400; a later request to 0x1000 misses again.
- Flush during FILL: flush_in at 2nd response -> all 4 words still fetched, no instr_valid pulse, if_req_ready=1 after fill; a re-request hits in 1 cycle.
- rdy_in low for 3 cycles mid-fill -> counter and outputs frozen; fill resumes and completes correctly.
- Reset mid-fill: assert rst_in=0 after 2 words -> outputs go to 0 immediately; a re-request of the same PC misses (line not valid).

Source files
------------

// File: rtl/icache_direct_if.sv
// Bus bundle for the direct-mapped instruction cache.
// Carries two channels:
//   - fetch side: if_req_valid/if_pc in, if_req_ready/instr_valid/instr_out out.
//   - memory side: mem_req_valid/mem_req_addr out, mem_resp_valid/mem_resp_data in.
// The slave modport is the cache. The master modport is its environment: the fetch
// unit plus the memory controller.
interface icache_direct_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  if_req_valid;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic                  if_req_ready;
    logic                  instr_valid;
    logic [31:0]           instr_out;
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [31:0]           mem_resp_data;

    modport slave (
        input  if_req_valid, if_pc, mem_resp_valid, mem_resp_data,
        output if_req_ready, instr_valid, instr_out, mem_req_valid, mem_req_addr
    );

    modport master (
        output if_req_valid, if_pc, mem_resp_valid, mem_resp_data,
        input  if_req_ready, instr_valid, instr_out, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache in front of the fetch queue.
// Ports:
//   clk_in   - clock, rising edge
//   rst_in   - asynchronous active-low reset
//   rdy_in   - global ready; when low every register holds
//   flush_in - pipeline redirect; cancels the pending fetch
//   bus      - icache_direct_if.slave (fetch request/response + memory refill channel)
// A hit answers one cycle after accept. A miss refills the whole line word by word,
// then answers in the RESP state.
module icache_direct #(
    parameter int unsigned INDEX_BITS    = 6,
    parameter int unsigned WORD_OFF_BITS = 2,
    parameter int unsigned ADDR_WIDTH    = 32
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    input  logic           flush_in,
    icache_direct_if.slave bus
);
    localparam int unsigned Lines   = 1 << INDEX_BITS;
    localparam int unsigned Words   = 1 << WORD_OFF_BITS;
    localparam int unsigned IdxLsb  = 2 + WORD_OFF_BITS;
    localparam int unsigned TagLsb  = IdxLsb + INDEX_BITS;
    localparam int unsigned TagBits = ADDR_WIDTH - TagLsb;

    typedef enum logic [1:0] {StIdle, StFill, StResp} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:2]    pc_q, pc_d;
    logic [WORD_OFF_BITS-1:0] cnt_q, cnt_d;
    logic                     cancel_q, cancel_d;
    logic                     instr_valid_q, instr_valid_d;
    logic [31:0]              instr_out_q, instr_out_d;
    logic                     mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0]    mem_req_addr_q, mem_req_addr_d;
    logic [Lines-1:0]         valid_q;

    logic [TagBits-1:0]       tag_mem  [Lines];
    logic [31:0]              data_mem [Lines][Words];

    logic [TagBits-1:0]       req_tag, fill_tag;
    logic [INDEX_BITS-1:0]    req_idx, fill_idx;
    logic [WORD_OFF_BITS-1:0] req_word, fill_word, cnt_inc;
    logic                     hit, accept, fill_we, fill_last;
    logic                     unused_pc_bits;

    assign req_tag   = bus.if_pc[ADDR_WIDTH-1:TagLsb];
    assign req_idx   = bus.if_pc[TagLsb-1:IdxLsb];
    assign req_word  = bus.if_pc[IdxLsb-1:2];
    assign fill_tag  = pc_q[ADDR_WIDTH-1:TagLsb];
    assign fill_idx  = pc_q[TagLsb-1:IdxLsb];
    assign fill_word = pc_q[IdxLsb-1:2];
    assign cnt_inc   = cnt_q + 1'b1;
    assign unused_pc_bits = ^bus.if_pc[1:0];

    assign hit    = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign accept = (state_q == StIdle) && bus.if_req_valid && !flush_in;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        cnt_d           = cnt_q;
        cancel_d        = cancel_q;
        instr_valid_d   = 1'b0;
        instr_out_d     = instr_out_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        fill_we         = 1'b0;
        fill_last       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    pc_d = bus.if_pc[ADDR_WIDTH-1:2];
                    if (hit) begin
                        instr_valid_d = 1'b1;
                        instr_out_d   = data_mem[req_idx][req_word];
                    end else begin
                        state_d         = StFill;
                        cnt_d           = '0;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {req_tag, req_idx, {WORD_OFF_BITS{1'b0}}, 2'b00};
                    end
                end
            end
            StFill: begin
                // The refill always runs to completion; a flush only kills the answer.
                if (flush_in) begin
                    cancel_d = 1'b1;
                end
                if (bus.mem_resp_valid) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_inc;
                    if (&cnt_q) begin
                        fill_last       = 1'b1;
                        state_d         = StResp;
                        mem_req_valid_d = 1'b0;
                        // The answer pulse is registered here so it is high during RESP.
                        instr_valid_d   = !cancel_q && !flush_in;
                        instr_out_d     = (fill_word == cnt_q) ? bus.mem_resp_data
                                                               : data_mem[fill_idx][fill_word];
                    end else begin
                        mem_req_addr_d = {fill_tag, fill_idx, cnt_inc, 2'b00};
                    end
                end
            end
            StResp: begin
                state_d  = StIdle;
                cancel_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= StIdle;
            pc_q            <= '0;
            cnt_q           <= '0;
            cancel_q        <= 1'b0;
            instr_valid_q   <= 1'b0;
            instr_out_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            valid_q         <= '0;
        end else if (rdy_in) begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            cnt_q           <= cnt_d;
            cancel_q        <= cancel_d;
            instr_valid_q   <= instr_valid_d;
            instr_out_q     <= instr_out_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            if (fill_last) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Storage arrays need no reset: the valid bits guard every read.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            data_mem[fill_idx][cnt_q] <= bus.mem_resp_data;
            if (fill_last) begin
                tag_mem[fill_idx] <= fill_tag;
            end
        end
    end

    // Gated by rdy_in so a requester never sees a handshake that the frozen cache ignores.
    assign bus.if_req_ready  = (state_q == StIdle) && rdy_in;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr_out     = instr_out_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst_in, rdy_in, flush_in;
    always #5 clk = ~clk;

    icache_direct_if bus ();

    icache_direct dut (
        .clk_in  (clk),
        .rst_in  (rst_in),
        .rdy_in  (rdy_in),
        .flush_in(flush_in),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] data;
        int          at;      // required arrival cycle, -1 = any
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          resp_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        nchk++;
        if (got !== req) begin
            nerr++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Backing memory contents, written out by hand per line.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] base;
        case (a[31:4])
            28'h0000100: base = 32'hA0;
            28'h0000140: base = 32'hB0;
            28'h0000200: base = 32'hC0;
            28'h0000305: base = 32'hD0;
            28'h0000400: base = 32'hE0;
            default:     base = 32'hEEEE_0000;
        endcase
        return base + {30'd0, a[3:2]};
    endfunction

    // Monitor: pops the scoreboard whenever the cache presents an instruction.
    initial begin
        bit   act;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            act = rdy_in && rst_in;
            #1;
            if (act && bus.instr_valid) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_instr got=%h required=no pulse", bus.instr_out);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_out", bus.instr_out, e.data);
                    if (e.at >= 0) check("hit_latency", cyc, e.at);
                end
            end
        end
    end

    // Memory controller model: one request in flight, checks each requested address.
    initial begin
        bit          act;
        int          cd;
        logic [31:0] cur;
        cd = 0;
        cur = '0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(posedge clk);
            act = rdy_in && rst_in;
            #1;
            if (!rst_in) begin
                cd = 0;
                bus.mem_resp_valid = 1'b0;
            end else if (act) begin
                if (bus.mem_resp_valid) begin
                    bus.mem_resp_valid = 1'b0;
                    resp_cnt++;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_data  = mem_word(cur);
                    end
                end else if (bus.mem_req_valid) begin
                    if (exp_addr_q.size() == 0) begin
                        nchk++;
                        nerr++;
                        $display("FAIL unexpected_mem_req got=%h required=no request",
                                 bus.mem_req_addr);
                    end else begin
                        check("mem_req_addr", bus.mem_req_addr, exp_addr_q.pop_front());
                    end
                    cur = bus.mem_req_addr;
                    cd  = 1;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; leaves at posedge+1 so calls can run back to back.
    task automatic issue(input logic [31:0] pc, input logic [31:0] data, input bit hit,
                         input bit want_resp);
        exp_t e;
        int   t = 0;
        while (!bus.if_req_ready && t < 300) begin
            sync();
            t++;
        end
        check("req_ready_wait", {31'd0, bus.if_req_ready}, 32'd1);
        if (!hit) begin
            for (int w = 0; w < 4; w++) begin
                logic [1:0] wi = w[1:0];
                exp_addr_q.push_back({pc[31:4], wi, 2'b00});
            end
        end
        if (want_resp) begin
            e.data = data;
            e.at   = hit ? cyc + 1 : -1;
            exp_q.push_back(e);
        end
        bus.if_req_valid = 1'b1;
        bus.if_pc        = pc;
        sync();
        bus.if_req_valid = 1'b0;
        bus.if_pc        = 32'hDEAD_BEEF;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(bus.if_req_ready && !bus.mem_req_valid && exp_q.size() == 0 &&
                 exp_addr_q.size() == 0) && t < 500) begin
            sync();
            t++;
        end
        check("idle_wait", {31'd0, (t < 500)}, 32'd1);
        repeat (3) sync();
    endtask

    task automatic wait_resp(input int target);
        int t = 0;
        while (resp_cnt < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("resp_wait", {31'd0, (resp_cnt >= target)}, 32'd1);
    endtask

    initial begin
        int base;
        int t;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        flush_in = 1'b0;
        bus.if_req_valid = 1'b0;
        bus.if_pc = '0;
        repeat (2) @(negedge clk);
        check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr_out", bus.instr_out, 32'd0);
        check("rst_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        check("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
        check("rst_req_ready", {31'd0, bus.if_req_ready}, 32'd1);
        rst_in = 1'b1;
        sync();

        // Cold miss, then hits (back to back) on the filled line.
        issue(32'h0000_1004, 32'hA1, 1'b0, 1'b1);
        wait_idle();
        issue(32'h0000_100C, 32'hA3, 1'b1, 1'b1);
        issue(32'h0000_1000, 32'hA0, 1'b1, 1'b1);
        issue(32'h0000_1008, 32'hA2, 1'b1, 1'b1);
        wait_idle();

        // Conflict eviction on index 0.
        issue(32'h0000_1404, 32'hB1, 1'b0, 1'b1);
        wait_idle();
        issue(32'h0000_1000, 32'hA0, 1'b0, 1'b1);
        wait_idle();
        issue(32'h0000_1004, 32'hA1, 1'b1, 1'b1);
        wait_idle();

        // Flush while the second refill word is arriving.
        base = resp_cnt;
        issue(32'h0000_2000, 32'h0, 1'b0, 1'b0);
        wait_resp(base + 1);
        t = 0;
        while (!bus.mem_resp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("flush_resp_wait", {31'd0, bus.mem_resp_valid}, 32'd1);
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        sync();
        wait_idle();
        check("flush_resp_count", resp_cnt - base, 32'd4);
        check("flush_ready_after", {31'd0, bus.if_req_ready}, 32'd1);
        issue(32'h0000_2008, 32'hC2, 1'b1, 1'b1);
        wait_idle();

        // Global stall for three cycles mid-fill.
        base = resp_cnt;
        issue(32'h0000_3054, 32'hD1, 1'b0, 1'b1);
        wait_resp(base + 2);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
            check("stall_mem_req_addr", bus.mem_req_addr, 32'h0000_3058);
            check("stall_req_ready", {31'd0, bus.if_req_ready}, 32'd0);
        end
        rdy_in = 1'b1;
        sync();
        wait_idle();

        // Reset after two refill words: line must not become valid.
        base = resp_cnt;
        issue(32'h0000_4004, 32'h0, 1'b0, 1'b0);
        wait_resp(base + 2);
        rst_in = 1'b0;
        #1;
        check("midrst_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        check("midrst_mem_req_addr", bus.mem_req_addr, 32'd0);
        check("midrst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("midrst_pending_addrs", exp_addr_q.size(), 32'd2);
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        rst_in = 1'b1;
        sync();
        issue(32'h0000_4004, 32'hE1, 1'b0, 1'b1);
        wait_idle();

        check("final_instr_queue", exp_q.size(), 32'd0);
        check("final_addr_queue", exp_addr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
